// File: rtl/instmem_pkg.sv
// instmem_pkg: shared types and defaults for the loadable instruction memory.
package instmem_pkg;
    localparam int IW_DEF = 9;
    localparam int AW_DEF = 8;
    localparam logic [IW_DEF-1:0] NOP_DEF = '0;
    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
endpackage

// File: rtl/instmem_loadable_if.sv
// instmem_loadable_if: program-load stream and fetch port of the instruction memory.
interface instmem_loadable_if
    import instmem_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
);
    logic          prog_start;
    logic          prog_valid;
    logic [IW-1:0] prog_data;
    logic          prog_last;
    logic          prog_ready;
    logic          prog_err;
    logic          load_done;
    logic [AW:0]   load_count;
    logic [AW-1:0] pc;
    logic          fetch_en;
    logic [IW-1:0] inst;
    logic          inst_valid;
    modport master (
        output prog_start, prog_valid, prog_data, prog_last, pc, fetch_en,
        input  prog_ready, prog_err, load_done, load_count, inst, inst_valid
    );
    modport slave (
        input  prog_start, prog_valid, prog_data, prog_last, pc, fetch_en,
        output prog_ready, prog_err, load_done, load_count, inst, inst_valid
    );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single-write, single-read synchronous RAM with registered read data.
module imem_ram #(
    parameter int IW = 9,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [2**AW];
    logic [IW-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_q <= mem[raddr];
    end
    assign rdata = rd_q;
endmodule

// File: rtl/instmem_loadable.sv
// instmem_loadable: instruction memory loaded by a beat stream, zero-filled to the end,
// and fetchable only once the whole image is in place.
module instmem_loadable
    import instmem_pkg::*;
#(
    parameter int            IW  = IW_DEF,
    parameter int            AW  = AW_DEF,
    parameter logic [IW-1:0] NOP = {IW{1'b0}}
) (
    input logic                clk,
    input logic                reset,
    instmem_loadable_if.slave  bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d, nop_q, nop_d, iv_q, iv_d;
    logic          acc, fill_we, fetch;
    logic [IW-1:0] rd;
    assign bus.prog_ready = state_q == LOAD && !bus.prog_start;
    always_comb begin
        acc     = bus.prog_valid && bus.prog_ready;
        fill_we = state_q == FILL && !bus.prog_start;
        fetch   = state_q == DONE && bus.fetch_en;
        state_d = state_q;
        wptr_d  = (acc || fill_we) ? wptr_q + AW'(1) : wptr_q;
        cnt_d   = acc ? cnt_q + (AW+1)'(1) : cnt_q;
        err_d   = err_q || (bus.prog_valid && state_q != LOAD);
        // The read register is only refreshed on a fetch, so NOP masking tracks gating separately.
        nop_d   = state_q != DONE ? 1'b1 : fetch ? 1'b0 : nop_q;
        iv_d    = fetch;
        if (acc && (bus.prog_last || wptr_q == '1)) state_d = wptr_q == '1 ? DONE : FILL;
        if (fill_we && wptr_q == '1) state_d = DONE;
        if (bus.prog_start) begin
            state_d = LOAD;
            wptr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            nop_q   <= 1'b1;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            nop_q   <= nop_d;
            iv_q    <= iv_d;
        end
    end
    imem_ram #(.IW(IW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (acc || fill_we),
        .waddr (wptr_q),
        .wdata (acc ? bus.prog_data : NOP),
        .re    (fetch),
        .raddr (bus.pc),
        .rdata (rd)
    );
    assign bus.inst       = nop_q ? NOP : rd;
    assign bus.inst_valid = iv_q;
    assign bus.load_done  = state_q == DONE;
    assign bus.load_count = cnt_q;
    assign bus.prog_err   = err_q;
endmodule

// File: tb/tb_instmem_loadable.sv
// tb_instmem_loadable: directed scenario tasks for the loadable instruction memory.
module tb_instmem_loadable;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    instmem_loadable_if #(.IW(9), .AW(8)) bus ();
    instmem_loadable #(.IW(9), .AW(8)) dut (.clk(clk), .reset(rst), .bus(bus));
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.load_done && n < 400) begin
            step();
            n++;
        end
    endtask
    task automatic fetch_chk(input logic [7:0] a, input logic [8:0] exp, input string nm);
        bus.pc = a;
        bus.fetch_en = 1'b1;
        step();
        tests++;
        if (bus.inst !== exp || bus.inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s: inst=%h valid=%b required inst=%h valid=1", nm, bus.inst, bus.inst_valid, exp);
        end
        bus.fetch_en = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++;
        if (bus.inst !== 9'h000 || bus.inst_valid !== 1'b0 || bus.load_done !== 1'b0 ||
            bus.load_count !== 9'd0 || bus.prog_err !== 1'b0 || bus.prog_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset: inst=%h v=%b done=%b cnt=%0d err=%b rdy=%b required all zero",
                     bus.inst, bus.inst_valid, bus.load_done, bus.load_count, bus.prog_err, bus.prog_ready);
        end
        bus.pc = 8'd0;
        bus.fetch_en = 1'b1;
        step();
        tests++;
        if (bus.inst !== 9'h000 || bus.inst_valid !== 1'b0 || bus.load_done !== 1'b0) begin
            fails++;
            $display("FAIL gated_fetch: inst=%h v=%b done=%b required 000/0/0", bus.inst, bus.inst_valid, bus.load_done);
        end
        bus.fetch_en = 1'b0;
    endtask
    task automatic test_short_load;
        logic [8:0] d [3] = '{9'h093, 9'h14B, 9'h154};
        int n;
        bus.prog_start = 1'b1;
        step();
        bus.prog_start = 1'b0;
        #1;
        tests++;
        if (bus.prog_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_in_load: got %b required 1", bus.prog_ready);
        end
        for (int i = 0; i < 3; i++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data = d[i];
            bus.prog_last = (i == 2);
            step();
        end
        bus.prog_valid = 1'b0;
        bus.prog_last = 1'b0;
        tests++;
        if (bus.load_count !== 9'd3 || bus.load_done !== 1'b0) begin
            fails++;
            $display("FAIL short_count: cnt=%0d done=%b required 3/0", bus.load_count, bus.load_done);
        end
        wait_done(n);
        tests++;
        if (n != 253 || bus.load_done !== 1'b1) begin
            fail_fill: begin
                fails++;
                $display("FAIL fill_cycles: got %0d done=%b required 253/1", n, bus.load_done);
            end
        end
        fetch_chk(8'd0, 9'h093, "fetch_pc0");
        bus.fetch_en = 1'b1;
        fetch_chk(8'd1, 9'h14B, "fetch_pc1");
        bus.fetch_en = 1'b1;
        fetch_chk(8'd2, 9'h154, "fetch_pc2");
        step();
        tests++;
        if (bus.inst !== 9'h154 || bus.inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL fetch_hold: inst=%h v=%b required 154/0", bus.inst, bus.inst_valid);
        end
        fetch_chk(8'd3, 9'h000, "fetch_pc3_fill");
        fetch_chk(8'd255, 9'h000, "fetch_pc255_fill");
    endtask
    task automatic test_full_load;
        bus.prog_start = 1'b1;
        step();
        bus.prog_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data = 9'(i);
            step();
        end
        bus.prog_valid = 1'b0;
        tests++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 9'd256) begin
            fails++;
            $display("FAIL full_load: done=%b cnt=%0d required 1/256", bus.load_done, bus.load_count);
        end
        fetch_chk(8'd200, 9'd200, "full_pc200");
        fetch_chk(8'd255, 9'd255, "full_pc255");
    endtask
    task automatic test_err;
        bus.prog_valid = 1'b1;
        bus.prog_data = 9'h1FF;
        step();
        bus.prog_valid = 1'b0;
        step();
        tests++;
        if (bus.prog_err !== 1'b1 || bus.load_count !== 9'd256) begin
            fails++;
            $display("FAIL err_sticky: err=%b cnt=%0d required 1/256", bus.prog_err, bus.load_count);
        end
        fetch_chk(8'd0, 9'd0, "err_ram_pc0");
        fetch_chk(8'd1, 9'd1, "err_ram_pc1");
        bus.prog_start = 1'b1;
        step();
        bus.prog_start = 1'b0;
        tests++;
        if (bus.prog_err !== 1'b0 || bus.load_done !== 1'b0 || bus.load_count !== 9'd0) begin
            fails++;
            $display("FAIL err_clear: err=%b done=%b cnt=%0d required 0/0/0", bus.prog_err, bus.load_done, bus.load_count);
        end
    endtask
    task automatic test_restart;
        int n;
        for (int i = 0; i < 4; i++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data = 9'h011 + 9'(i);
            step();
        end
        bus.prog_data = 9'h0AA;
        bus.prog_start = 1'b1;
        #1;
        tests++;
        if (bus.prog_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_on_start: got %b required 0", bus.prog_ready);
        end
        step();
        bus.prog_start = 1'b0;
        tests++;
        if (bus.load_count !== 9'd0) begin
            fails++;
            $display("FAIL restart_count: got %0d required 0", bus.load_count);
        end
        bus.prog_data = 9'h1A1;
        step();
        bus.prog_data = 9'h0B2;
        bus.prog_last = 1'b1;
        step();
        bus.prog_valid = 1'b0;
        bus.prog_last = 1'b0;
        tests++;
        if (bus.load_count !== 9'd2) begin
            fails++;
            $display("FAIL reload_count: got %0d required 2", bus.load_count);
        end
        wait_done(n);
        tests++;
        if (n != 254) begin
            fails++;
            $display("FAIL reload_fill: got %0d required 254", n);
        end
        fetch_chk(8'd0, 9'h1A1, "reload_pc0");
        fetch_chk(8'd1, 9'h0B2, "reload_pc1");
        fetch_chk(8'd3, 9'h000, "reload_pc3");
    endtask
    task automatic test_reset_mid_fill;
        bus.prog_start = 1'b1;
        step();
        bus.prog_start = 1'b0;
        bus.prog_valid = 1'b1;
        bus.prog_data = 9'h155;
        bus.prog_last = 1'b1;
        step();
        bus.prog_valid = 1'b0;
        bus.prog_last = 1'b0;
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (bus.load_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_fill_done: got %b required 0", bus.load_done);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (bus.load_done !== 1'b0 || bus.inst !== 9'h000 || bus.inst_valid !== 1'b0 ||
            bus.load_count !== 9'd0 || bus.prog_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_fill: done=%b inst=%h v=%b cnt=%0d rdy=%b required 0/000/0/0/0",
                     bus.load_done, bus.inst, bus.inst_valid, bus.load_count, bus.prog_ready);
        end
        bus.pc = 8'd0;
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.inst_valid !== 1'b0 || bus.inst !== 9'h000) begin
                fails++;
                $display("FAIL post_reset_fetch: inst=%h v=%b required 000/0", bus.inst, bus.inst_valid);
            end
        end
        bus.fetch_en = 1'b0;
    endtask
    initial begin
        bus.prog_start = 1'b0;
        bus.prog_valid = 1'b0;
        bus.prog_data = '0;
        bus.prog_last = 1'b0;
        bus.pc = '0;
        bus.fetch_en = 1'b0;
        test_reset();
        test_short_load();
        test_full_load();
        test_err();
        test_restart();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
